// File: rtl/ex_fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit. Shadows the EX destination through
// EX/MEM and MEM/WB copies to drive ALU operand selects and the ID stall request.
module ex_fwd_hazard_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush_ex,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use_stall,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_reg_write,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_reg_write,
  output logic [CNT_W-1:0] load_use_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_read_q, mem_mem_read_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic [CNT_W-1:0] load_use_count_q, load_use_count_d;
  logic             mem_wr_valid, wb_wr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dest_q       <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      wb_dest_q        <= '0;
      wb_reg_write_q   <= 1'b0;
      load_use_count_q <= '0;
    end else begin
      mem_dest_q       <= mem_dest_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      wb_dest_q        <= wb_dest_d;
      wb_reg_write_q   <= wb_reg_write_d;
      load_use_count_q <= load_use_count_d;
    end
  end

  // A freeze beats a flush: the squashed instruction stays put until the pipe moves.
  always_comb begin
    mem_dest_d      = mem_dest_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_mem_read_d  = mem_mem_read_q;
    wb_dest_d       = wb_dest_q;
    wb_reg_write_d  = wb_reg_write_q;
    if (!stall_in) begin
      wb_dest_d      = mem_dest_q;
      wb_reg_write_d = mem_reg_write_q;
      if (flush_ex) begin
        mem_dest_d      = '0;
        mem_reg_write_d = 1'b0;
        mem_mem_read_d  = 1'b0;
      end else begin
        mem_dest_d      = ex_dest;
        mem_reg_write_d = ex_reg_write;
        mem_mem_read_d  = ex_mem_read;
      end
    end
  end

  assign mem_wr_valid = mem_reg_write_q && (mem_dest_q != '0);
  assign wb_wr_valid  = wb_reg_write_q && (wb_dest_q != '0);

  always_comb begin
    fwd_a = 2'b00;
    if (mem_wr_valid && (mem_dest_q == ex_rs)) begin
      fwd_a = 2'b10;
    end else if (wb_wr_valid && (wb_dest_q == ex_rs)) begin
      fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_wr_valid && (mem_dest_q == ex_rt)) begin
      fwd_b = 2'b10;
    end else if (wb_wr_valid && (wb_dest_q == ex_rt)) begin
      fwd_b = 2'b01;
    end
  end

  always_comb begin
    load_use_stall = 1'b0;
    if (!flush_ex && ex_mem_read && ex_reg_write && (ex_dest != '0) &&
        ((ex_dest == id_rs) || (ex_dest == id_rt))) begin
      load_use_stall = 1'b1;
    end
  end

  always_comb begin
    load_use_count_d = load_use_count_q;
    if (load_use_stall && !stall_in && (load_use_count_q != CntMax)) begin
      load_use_count_d = load_use_count_q + 1'b1;
    end
  end

  assign mem_dest       = mem_dest_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign wb_dest        = wb_dest_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign load_use_count = load_use_count_q;

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
// Bench for ex_fwd_hazard_unit: table of per-cycle vectors with hand-derived
// expectations, plus reset, stall/flush, saturation and async-reset sequences.
module tb_ex_fwd_hazard_unit;

  localparam int unsigned RegW = 5;
  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       lus;
    logic [4:0] md;
    logic       mrw;
    logic [4:0] wd;
    logic       wrw;
    logic [3:0] cnt;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            stall_in = 1'b0;
  logic            flush_ex = 1'b0;
  logic [RegW-1:0] ex_dest = '0;
  logic            ex_reg_write = 1'b0;
  logic            ex_mem_read = 1'b0;
  logic [RegW-1:0] ex_rs = '0;
  logic [RegW-1:0] ex_rt = '0;
  logic [RegW-1:0] id_rs = '0;
  logic [RegW-1:0] id_rt = '0;
  logic [1:0]      fwd_a, fwd_b;
  logic            load_use_stall;
  logic [RegW-1:0] mem_dest, wb_dest;
  logic            mem_reg_write, wb_reg_write;
  logic [CntW-1:0] load_use_count;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  ex_fwd_hazard_unit #(
    .REG_W(RegW),
    .CNT_W(CntW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_in      (stall_in),
    .flush_ex      (flush_ex),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .load_use_stall(load_use_stall),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .load_use_count(load_use_count)
  );

  function automatic vec_t mk(input logic st, input logic fl, input logic [4:0] d,
                              input logic rw, input logic mr, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] irs,
                              input logic [4:0] irt, input logic [1:0] fa,
                              input logic [1:0] fb, input logic lus, input logic [4:0] md,
                              input logic mrw, input logic [4:0] wd, input logic wrw,
                              input logic [3:0] cnt);
    vec_t v;
    v.stall = st; v.flush = fl; v.dest = d; v.rw = rw; v.mr = mr;
    v.rs = rs; v.rt = rt; v.id_rs = irs; v.id_rt = irt;
    v.fa = fa; v.fb = fb; v.lus = lus; v.md = md; v.mrw = mrw;
    v.wd = wd; v.wrw = wrw; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input int idx);
    chk("fwd_a", idx, 32'(fwd_a), 32'(e.fa));
    chk("fwd_b", idx, 32'(fwd_b), 32'(e.fb));
    chk("load_use_stall", idx, 32'(load_use_stall), 32'(e.lus));
    chk("mem_dest", idx, 32'(mem_dest), 32'(e.md));
    chk("mem_reg_write", idx, 32'(mem_reg_write), 32'(e.mrw));
    chk("wb_dest", idx, 32'(wb_dest), 32'(e.wd));
    chk("wb_reg_write", idx, 32'(wb_reg_write), 32'(e.wrw));
    chk("load_use_count", idx, 32'(load_use_count), 32'(e.cnt));
  endtask

  // Drive a vector after the falling edge, queue its expectation, compare shortly after.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    stall_in = v.stall; flush_ex = v.flush; ex_dest = v.dest;
    ex_reg_write = v.rw; ex_mem_read = v.mr; ex_rs = v.rs; ex_rt = v.rt;
    id_rs = v.id_rs; id_rt = v.id_rt;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    compare(e, idx);
  endtask

  initial begin
    // Expectations are the outputs seen before the edge that follows each vector.
    //          st fl dst rw mr rs  rt  irs irt  fa     fb     lus md  mrw wd wrw cnt
    tbl[0]  = mk(0, 0, 8,  1, 0, 5,  0,  0,  0,  2'b10, 2'b00, 0, 5,  1, 0,  0, 0);
    tbl[1]  = mk(0, 1, 0,  0, 0, 8,  9,  0,  0,  2'b10, 2'b00, 0, 8,  1, 5,  1, 0);
    tbl[2]  = mk(0, 0, 3,  1, 0, 8,  5,  0,  0,  2'b01, 2'b00, 0, 0,  0, 8,  1, 0);
    tbl[3]  = mk(0, 0, 3,  1, 0, 3,  3,  0,  0,  2'b10, 2'b10, 0, 3,  1, 0,  0, 0);
    tbl[4]  = mk(0, 0, 0,  1, 0, 3,  0,  0,  0,  2'b10, 2'b00, 0, 3,  1, 3,  1, 0);
    tbl[5]  = mk(0, 0, 0,  0, 0, 3,  0,  0,  0,  2'b01, 2'b00, 0, 0,  1, 3,  1, 0);
    tbl[6]  = mk(0, 0, 12, 1, 1, 0,  0,  0,  12, 2'b00, 2'b00, 1, 0,  0, 0,  1, 0);
    tbl[7]  = mk(0, 1, 12, 1, 1, 12, 0,  0,  12, 2'b10, 2'b00, 0, 12, 1, 0,  0, 1);
    tbl[8]  = mk(0, 0, 0,  1, 1, 12, 12, 0,  0,  2'b01, 2'b01, 0, 0,  0, 12, 1, 1);
    tbl[9]  = mk(1, 0, 7,  1, 1, 0,  0,  7,  0,  2'b00, 2'b00, 1, 0,  1, 0,  0, 1);
    tbl[10] = mk(0, 0, 7,  1, 0, 0,  0,  7,  0,  2'b00, 2'b00, 0, 0,  1, 0,  0, 1);
    tbl[11] = mk(0, 0, 9,  0, 1, 0,  0,  9,  0,  2'b00, 2'b00, 0, 7,  1, 0,  1, 1);

    // Reset held: writes presented to EX must not reach the shadows.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_vec(mk(0, 0, 5, 1, 0, 5, 5, 5, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 100 + i);
    end
    rst_n = 1'b1;  // the next edge captures ex_dest=5, checked by tbl[0]

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], i);
    end

    // Stall dominates flush, then a lone flush drains EX/MEM into MEM/WB.
    run_vec(mk(0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 9, 0, 7, 1, 1), 200);
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(1, 1, 4, 1, 0, 7, 0, 0, 0, 2'b10, 2'b00, 0, 7, 1, 9, 0, 1), 201 + i);
    end
    run_vec(mk(0, 1, 4, 1, 0, 7, 0, 0, 0, 2'b10, 2'b00, 0, 7, 1, 9, 0, 1), 204);
    run_vec(mk(0, 0, 0, 0, 0, 7, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 7, 1, 1), 205);

    // Saturation: count starts at 1 and must stop at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stall_in = 1'b0; flush_ex = 1'b0; ex_dest = 5'd12; ex_reg_write = 1'b1;
      ex_mem_read = 1'b1; id_rs = 5'd0; id_rt = 5'd12;
      #1;
      chk("sat_stall", i, 32'(load_use_stall), 32'd1);
      chk("sat_count", i, 32'(load_use_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    @(negedge clk);
    #1 chk("sat_final", 0, 32'(load_use_count), 32'd15);

    // Asynchronous reset between edges clears everything at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 0, 32'(load_use_count), 32'd0);
    chk("async_mem_dest", 0, 32'(mem_dest), 32'd0);
    chk("async_mem_rw", 0, 32'(mem_reg_write), 32'd0);
    chk("async_wb_rw", 0, 32'(wb_reg_write), 32'd0);
    ex_rs = 5'd12;
    #1 chk("async_fwd_a", 0, 32'(fwd_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
